polyphase_tap_seq: RTL and testbench

- Sequencer directly upstream of the register file in the sample-rate converter datapath.
- Accepts input samples over a valid/ready handshake and writes each one into the register file, which it uses as a circular delay line.
- Then issues paired tap reads (two taps per cycle on the A/B read ports) for every polyphase output phase.
- Emits aligned tap metadata for the downstream MAC stage, valid in the same cycle as the register file's ra/rb outputs.

---
 rtl/polyphase_tap_seq_if.sv | 41 ++++
 rtl/polyphase_tap_seq.sv | 161 ++++++++++++++++
 tb/tb_polyphase_tap_seq.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/polyphase_tap_seq_if.sv
// Bundle of the sample handshake, register-file command bus and aligned tap
// metadata shared by the polyphase tap sequencer and its neighbours.
interface polyphase_tap_seq_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int REGFILE_ADDR_W = 5,
   parameter int PHASE_W        = 2,
   parameter int PAIR_W         = 2
);
   logic                      in_valid;
   logic                      in_ready;
   logic [DATA_WIDTH-1:0]     in_data;
   logic                      hold;
   logic                      rf_en;
   logic                      rf_rw;
   logic [REGFILE_ADDR_W-1:0] rf_a_ra;
   logic [REGFILE_ADDR_W-1:0] rf_a_rb;
   logic [REGFILE_ADDR_W-1:0] rf_a_rd;
   logic [DATA_WIDTH-1:0]     rf_rd;
   logic                      tap_valid;
   logic [PHASE_W-1:0]        tap_phase;
   logic [PAIR_W-1:0]         tap_pair;
   logic                      tap_a_zero;
   logic                      tap_b_zero;
   logic                      tap_last;
   logic                      frame_done;
   logic [1:0]                state_dbg;

   modport master (
      input  in_valid, in_data, hold,
      output in_ready, rf_en, rf_rw, rf_a_ra, rf_a_rb, rf_a_rd, rf_rd,
             tap_valid, tap_phase, tap_pair, tap_a_zero, tap_b_zero,
             tap_last, frame_done, state_dbg
   );

   modport slave (
      output in_valid, in_data, hold,
      input  in_ready, rf_en, rf_rw, rf_a_ra, rf_a_rb, rf_a_rd, rf_rd,
             tap_valid, tap_phase, tap_pair, tap_a_zero, tap_b_zero,
             tap_last, frame_done, state_dbg
   );
endinterface

// File: rtl/polyphase_tap_seq.sv
// Writes each accepted sample into a circular delay line in the register file,
// then issues paired tap reads for every polyphase output phase.
module polyphase_tap_seq #(
   parameter int DATA_WIDTH     = 32,
   parameter int REGFILE_ADDR_W = 5,
   parameter int TAPS_PER_PHASE = 8,
   parameter int PHASES         = 4,
   parameter int PHASE_W        = 2,
   parameter int PAIR_W         = 2
) (
   input logic clk,
   input logic rst,
   polyphase_tap_seq_if.master bus
);

   localparam int NPAIR = TAPS_PER_PHASE / 2;
   // Tap index / fill width: holds 2*pair+1 and the saturated fill level.
   localparam int IDX_W = PAIR_W + 2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_READ  = 2'd2;

   localparam logic [REGFILE_ADDR_W-1:0] ADDR_ONE   = REGFILE_ADDR_W'(1);
   localparam logic [IDX_W-1:0]          IDX_ONE    = IDX_W'(1);
   localparam logic [IDX_W-1:0]          FILL_MAX   = IDX_W'(TAPS_PER_PHASE);
   localparam logic [PAIR_W-1:0]         PAIR_LAST  = PAIR_W'(NPAIR - 1);
   localparam logic [PHASE_W-1:0]        PHASE_LAST = PHASE_W'(PHASES - 1);

   if ((TAPS_PER_PHASE % 2) != 0 || TAPS_PER_PHASE < 2) begin : g_bad_taps_odd
      $error("TAPS_PER_PHASE must be even and nonzero");
   end
   if (TAPS_PER_PHASE > (2 ** REGFILE_ADDR_W)) begin : g_bad_taps_depth
      $error("TAPS_PER_PHASE exceeds the delay-line depth");
   end
   if (PHASES < 1 || (2 ** PHASE_W) < PHASES) begin : g_bad_phases
      $error("PHASES must be >= 1 and fit in PHASE_W");
   end
   if ((2 ** PAIR_W) < NPAIR) begin : g_bad_pair_w
      $error("PAIR_W too narrow for TAPS_PER_PHASE/2");
   end

   logic [1:0]                state_q;
   logic [REGFILE_ADDR_W-1:0] wptr_q;
   logic [REGFILE_ADDR_W-1:0] base_q;
   logic [IDX_W-1:0]          fill_q;
   logic [PHASE_W-1:0]        phase_q;
   logic [PAIR_W-1:0]         pair_q;
   logic [DATA_WIDTH-1:0]     sample_q;

   logic                      tap_valid_q;
   logic [PHASE_W-1:0]        tap_phase_q;
   logic [PAIR_W-1:0]         tap_pair_q;
   logic                      tap_a_zero_q;
   logic                      tap_b_zero_q;
   logic                      tap_last_q;
   logic                      frame_done_q;

   logic                      last_pair;
   logic                      last_phase;
   logic [IDX_W-1:0]          idx_a;
   logic [IDX_W-1:0]          idx_b;
   logic [REGFILE_ADDR_W-1:0] off_a;

   assign last_pair  = (pair_q == PAIR_LAST);
   assign last_phase = (phase_q == PHASE_LAST);
   assign idx_a      = {1'b0, pair_q, 1'b0};
   assign idx_b      = {1'b0, pair_q, 1'b1};
   assign off_a      = REGFILE_ADDR_W'({pair_q, 1'b0});

   // Sample handshake: a transfer happens on a rising edge where in_valid and
   // in_ready are both high; in_ready is a pure decode of IDLE and never
   // depends on in_valid, and in_data is only sampled on a transfer.
   always_comb begin
      bus.in_ready = 1'b0;
      bus.rf_en    = 1'b0;
      if (!rst) begin
         bus.in_ready = (state_q == S_IDLE);
         bus.rf_en    = (state_q == S_WRITE) || ((state_q == S_READ) && !bus.hold);
      end
   end

   assign bus.rf_rw      = (state_q == S_READ);
   assign bus.rf_a_rd    = wptr_q;
   assign bus.rf_rd      = sample_q;
   // Tap 2p sits 2p samples behind the newest one at base.
   assign bus.rf_a_ra    = base_q - off_a;
   assign bus.rf_a_rb    = base_q - off_a - ADDR_ONE;

   assign bus.tap_valid  = tap_valid_q;
   assign bus.tap_phase  = tap_phase_q;
   assign bus.tap_pair   = tap_pair_q;
   assign bus.tap_a_zero = tap_a_zero_q;
   assign bus.tap_b_zero = tap_b_zero_q;
   assign bus.tap_last   = tap_last_q;
   assign bus.frame_done = frame_done_q;
   assign bus.state_dbg  = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         wptr_q       <= '0;
         base_q       <= '0;
         fill_q       <= '0;
         phase_q      <= '0;
         pair_q       <= '0;
         sample_q     <= '0;
         tap_valid_q  <= 1'b0;
         tap_phase_q  <= '0;
         tap_pair_q   <= '0;
         tap_a_zero_q <= 1'b0;
         tap_b_zero_q <= 1'b0;
         tap_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         tap_valid_q  <= 1'b0;
         tap_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.in_valid) begin
                  sample_q <= bus.in_data;
                  state_q  <= S_WRITE;
               end
            end
            S_WRITE: begin
               base_q  <= wptr_q;
               wptr_q  <= wptr_q + ADDR_ONE;
               if (fill_q < FILL_MAX) begin
                  fill_q <= fill_q + IDX_ONE;
               end
               phase_q <= '0;
               pair_q  <= '0;
               state_q <= S_READ;
            end
            S_READ: begin
               if (!bus.hold) begin
                  tap_valid_q  <= 1'b1;
                  tap_phase_q  <= phase_q;
                  tap_pair_q   <= pair_q;
                  tap_a_zero_q <= (idx_a >= fill_q);
                  tap_b_zero_q <= (idx_b >= fill_q);
                  tap_last_q   <= last_pair;
                  frame_done_q <= last_pair && last_phase;
                  if (last_pair) begin
                     pair_q  <= '0;
                     phase_q <= phase_q + PHASE_W'(1);
                     if (last_phase) begin
                        state_q <= S_IDLE;
                     end
                  end else begin
                     pair_q <= pair_q + PAIR_W'(1);
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_polyphase_tap_seq.sv
// Scoreboard bench for polyphase_tap_seq: expected writes, read addresses and
// tap metadata are queued per accepted sample and popped by a monitor.
module tb_polyphase_tap_seq;
   localparam int DW     = 32;
   localparam int AW     = 5;
   localparam int TAPS   = 8;
   localparam int PHASES = 4;
   localparam int PHW    = 2;
   localparam int PRW    = 2;
   localparam int NPAIR  = TAPS / 2;
   localparam int TAP_W  = PHW + PRW + 4;
   localparam int RD_W   = 2 * AW;
   localparam int WR_W   = AW + DW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   polyphase_tap_seq_if #(.DATA_WIDTH(DW), .REGFILE_ADDR_W(AW), .PHASE_W(PHW), .PAIR_W(PRW)) bus ();

   polyphase_tap_seq #(
      .DATA_WIDTH(DW), .REGFILE_ADDR_W(AW), .TAPS_PER_PHASE(TAPS),
      .PHASES(PHASES), .PHASE_W(PHW), .PAIR_W(PRW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [TAP_W-1:0] exp_q[$];
   logic [RD_W-1:0]  rd_q[$];
   logic [WR_W-1:0]  wr_q[$];

   int total  = 0;
   int bad    = 0;
   int k      = 0;
   int tv_seen = 0;
   int fd_seen = 0;
   int exp_tv  = 0;
   int exp_fd  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Expected traffic for the kk-th sample since reset.
   function automatic void push_frame(input int kk, input logic [DW-1:0] d);
      int fill;
      logic [AW-1:0] base;
      logic [AW-1:0] ra;
      logic [AW-1:0] rb;
      fill = (kk + 1 < TAPS) ? kk + 1 : TAPS;
      base = AW'(kk);
      wr_q.push_back({base, d});
      for (int ph = 0; ph < PHASES; ph++) begin
         for (int p = 0; p < NPAIR; p++) begin
            ra = base - AW'(2 * p);
            rb = ra - AW'(1);
            rd_q.push_back({ra, rb});
            exp_q.push_back({PHW'(ph), PRW'(p), 1'(2 * p >= fill), 1'(2 * p + 1 >= fill),
                             1'(p == NPAIR - 1), 1'(p == NPAIR - 1 && ph == PHASES - 1)});
         end
      end
      exp_tv += PHASES * NPAIR;
      exp_fd++;
   endfunction

   always @(negedge clk) begin
      if (bus.rf_en && !bus.rf_rw) begin
         if (wr_q.size() == 0) chk("rf_write_unexpected", {bus.rf_a_rd, bus.rf_rd}, '1);
         else chk("rf_write", {bus.rf_a_rd, bus.rf_rd}, wr_q.pop_front());
      end
      if (bus.rf_en && bus.rf_rw) begin
         if (rd_q.size() == 0) chk("rf_read_unexpected", {bus.rf_a_ra, bus.rf_a_rb}, '1);
         else chk("rf_read", {bus.rf_a_ra, bus.rf_a_rb}, rd_q.pop_front());
      end
      if (bus.tap_valid) begin
         tv_seen++;
         if (exp_q.size() == 0)
            chk("tap_unexpected", {bus.tap_phase, bus.tap_pair, bus.tap_a_zero,
                                   bus.tap_b_zero, bus.tap_last, bus.frame_done}, '1);
         else
            chk("tap_meta", {bus.tap_phase, bus.tap_pair, bus.tap_a_zero,
                             bus.tap_b_zero, bus.tap_last, bus.frame_done}, exp_q.pop_front());
      end else begin
         chk("idle_tap_last", bus.tap_last, 1'b0);
      end
      if (bus.frame_done) fd_seen++;
   end

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.hold     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", bus.in_ready, 1'b0);
      chk("rst_rf_en", bus.rf_en, 1'b0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", bus.in_ready, 1'b1);
      chk("post_rst_tap_valid", bus.tap_valid, 1'b0);
      chk("post_rst_frame_done", bus.frame_done, 1'b0);
      chk("post_rst_state", bus.state_dbg, 2'd0);
      exp_q.delete();
      rd_q.delete();
      wr_q.delete();
      k = 0;
      exp_tv = tv_seen;
      exp_fd = fd_seen;
   endtask

   task automatic send(input logic [DW-1:0] d, output int unsigned acc);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      while (!bus.in_ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) chk("send_timeout", 1'b0, 1'b1);
      push_frame(k, d);
      k++;
      @(posedge clk);
      #1;
      acc = cyc;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || rd_q.size() != 0 || wr_q.size() != 0 || !bus.in_ready) && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({name, "_drain_timeout"}, (n >= 400), 1'b0);
      chk({name, "_tap_valid_count"}, tv_seen, exp_tv);
      chk({name, "_frame_done_count"}, fd_seen, exp_fd);
   endtask

   initial begin
      #2000000;
      total++;
      bad++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      int unsigned a0, a1, a, prev;
      int nacc, fd0, tv0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.hold     = 1'b0;

      // Single sample, then a full run of 34 samples wrapping the delay line.
      do_reset();
      send(32'h11, a0);
      chk("first_wr_addr", bus.rf_a_rd, 5'd0);
      chk("first_wr_data", bus.rf_rd, 32'h11);
      @(posedge clk);
      #1;
      chk("first_ra", bus.rf_a_ra, 5'd0);
      chk("first_rb", bus.rf_a_rb, 5'd31);
      send(32'h22, a1);
      chk("accept_spacing", a1 - a0, 18);
      chk("frame0_tap_valids", tv_seen, 16);
      chk("frame0_frame_done", fd_seen, 1);
      for (int i = 2; i < 34; i++) begin
         send(32'h100 + i, a);
         if (i == 33) begin
            chk("wrap_wr_addr", bus.rf_a_rd, 5'd1);
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            chk("wrap_pair1_ra", bus.rf_a_ra, 5'd31);
            chk("wrap_pair1_rb", bus.rf_a_rb, 5'd30);
         end
      end
      drain("run34");

      // Hold for three cycles after the fifth issue.
      do_reset();
      send(32'h33, a);
      repeat (6) begin
         @(posedge clk);
         #1;
      end
      bus.hold = 1'b1;
      #1;
      chk("hold0_rf_en", bus.rf_en, 1'b0);
      chk("hold0_ra", bus.rf_a_ra, 5'd30);
      chk("hold0_tap_valid", bus.tap_valid, 1'b1);
      @(posedge clk);
      #1;
      chk("hold1_rf_en", bus.rf_en, 1'b0);
      chk("hold1_tap_valid", bus.tap_valid, 1'b0);
      @(posedge clk);
      #1;
      chk("hold2_rf_en", bus.rf_en, 1'b0);
      chk("hold2_tap_valid", bus.tap_valid, 1'b0);
      chk("hold2_ra", bus.rf_a_ra, 5'd30);
      @(posedge clk);
      #1;
      bus.hold = 1'b0;
      #1;
      chk("release_tap_valid", bus.tap_valid, 1'b0);
      chk("release_rf_en", bus.rf_en, 1'b1);
      chk("release_ra", bus.rf_a_ra, 5'd30);
      drain("hold");

      // in_valid held high with data changing every cycle.
      do_reset();
      bus.in_valid = 1'b1;
      nacc = 0;
      prev = 0;
      for (int i = 0; i < 80; i++) begin
         bus.in_data = 32'hA000 + i;
         if (bus.in_ready) begin
            push_frame(k, bus.in_data);
            k++;
            if (nacc > 0) chk("stream_spacing", cyc - prev, 18);
            prev = cyc;
            nacc++;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      chk("stream_accepts", nacc, 5);
      drain("stream");

      // Reset in the middle of a frame at phase 1, pair 2.
      send(32'h5A5A, a);
      repeat (7) begin
         @(posedge clk);
         #1;
      end
      chk("abort_ra", bus.rf_a_ra, 5'd1);
      fd0 = fd_seen;
      do_reset();
      tv0 = tv_seen;
      repeat (20) begin
         @(posedge clk);
         #1;
      end
      chk("abort_no_frame_done", fd_seen, fd0);
      chk("abort_no_tap_valid", tv_seen, tv0);
      send(32'h77, a);
      chk("post_abort_wr_addr", bus.rf_a_rd, 5'd0);
      chk("post_abort_wr_data", bus.rf_rd, 32'h77);
      drain("post_abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
